// File: rtl/barrel_pkg.sv
// Shared constants and helpers for the pipelined logical barrel shifter.
package barrel_pkg;

  localparam int unsigned DEFAULT_N = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Bits needed to encode a shift amount for an n-bit word.
  function automatic int unsigned sh_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/barrel_shifter_logical.sv
// Combinational logical shifter: zero-fill, shifted-out bits are lost.
module barrel_shifter_logical
  import barrel_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic [N-1:0]             din,
  input  logic [sh_width(N)-1:0]   sh_amt,
  input  logic                     dir,
  output logic [N-1:0]             dout
);

  always_comb begin
    dout = din << sh_amt;
    if (dir == DIR_RIGHT) begin
      dout = din >> sh_amt;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Command FIFO feeding a logical barrel shifter, with a valid/ready result
// register and a count of consumed results.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_din,
  input  logic [sh_width(N)-1:0]   in_sh_amt,
  input  logic                     in_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_dout,
  output logic [sh_width(N)-1:0]   out_sh_amt,
  output logic                     out_dir,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [15:0]              done_cnt
);

  localparam int unsigned SW = sh_width(N);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [N-1:0]  mem_din_q [DEPTH];
  logic [SW-1:0] mem_amt_q [DEPTH];
  logic          mem_dir_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_dout_q, out_dout_d;
  logic [SW-1:0] out_amt_q, out_amt_d;
  logic          out_dir_q, out_dir_d;
  logic [15:0]   done_q, done_d;

  logic          push, pop, consume, fifo_empty;
  logic [N-1:0]  head_din;
  logic [SW-1:0] head_amt;
  logic          head_dir;
  logic [N-1:0]  shift_res;

  assign fifo_empty = (cnt_q == CW'(0));
  assign in_ready   = (cnt_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!out_valid_q || out_ready);
  assign consume    = out_valid_q && out_ready;

  assign head_din = mem_din_q[rd_ptr_q];
  assign head_amt = mem_amt_q[rd_ptr_q];
  assign head_dir = mem_dir_q[rd_ptr_q];

  barrel_shifter_logical #(.N(N)) u_shifter (
    .din    (head_din),
    .sh_amt (head_amt),
    .dir    (head_dir),
    .dout   (shift_res)
  );

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_din_q[wr_ptr_q] <= in_din;
      mem_amt_q[wr_ptr_q] <= in_sh_amt;
      mem_dir_q[wr_ptr_q] <= in_dir;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_dout_d  = out_dout_q;
    out_amt_d   = out_amt_q;
    out_dir_d   = out_dir_q;
    done_d      = done_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A pop on the consume edge reloads the register without a bubble.
    if (pop) begin
      out_valid_d = 1'b1;
      out_dout_d  = shift_res;
      out_amt_d   = head_amt;
      out_dir_d   = head_dir;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    if (consume) begin
      done_d = done_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_dout_q  <= '0;
      out_amt_q   <= '0;
      out_dir_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_dout_q  <= out_dout_d;
      out_amt_q   <= out_amt_d;
      out_dir_q   <= out_dir_d;
      done_q      <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_dout   = out_dout_q;
  assign out_sh_amt = out_amt_q;
  assign out_dir    = out_dir_q;
  assign fifo_cnt   = cnt_q;
  assign done_cnt   = done_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed self-checking bench for barrel_shift_pipe (N=8, DEPTH=4).
module tb_barrel_shift_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_din;
  logic [2:0] in_sh_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_dout;
  logic [2:0] out_sh_amt;
  logic       out_dir;
  logic [2:0] fifo_cnt;
  logic [15:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  barrel_shift_pipe #(.N(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_din     (in_din),
    .in_sh_amt  (in_sh_amt),
    .in_dir     (in_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dout   (out_dout),
    .out_sh_amt (out_sh_amt),
    .out_dir    (out_dir),
    .fifo_cnt   (fifo_cnt),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_din    = 8'h00;
    in_sh_amt = 3'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (fifo_cnt !== 3'd0) begin failures++; $display("FAIL reset_fifo_cnt got=%0h exp=0", fifo_cnt); end
    checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_done_cnt got=%0h exp=0", done_cnt); end
    checks++; if (out_dout !== 8'h00) begin failures++; $display("FAIL reset_out_dout got=%0h exp=0", out_dout); end
  endtask

  task automatic test_basic();
    logic [7:0] vin  [4];
    logic [2:0] vamt [4];
    logic       vdir [4];
    logic [7:0] vexp [4];
    vin[0] = 8'b10110011; vamt[0] = 3'd3; vdir[0] = 1'b0; vexp[0] = 8'b10011000;
    vin[1] = 8'b10110011; vamt[1] = 3'd2; vdir[1] = 1'b1; vexp[1] = 8'b00101100;
    vin[2] = 8'b10110011; vamt[2] = 3'd0; vdir[2] = 1'b1; vexp[2] = 8'b10110011;
    vin[3] = 8'b10110011; vamt[3] = 3'd7; vdir[3] = 1'b0; vexp[3] = 8'b10000000;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_din = vin[i]; in_sh_amt = vamt[i]; in_dir = vdir[i];
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic%0d_latency1 got=%0h exp=0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic%0d_valid got=%0h exp=1", i, out_valid); end
      checks++; if (out_dout !== vexp[i]) begin failures++; $display("FAIL basic%0d_dout got=%b exp=%b", i, out_dout, vexp[i]); end
      checks++; if ({out_sh_amt, out_dir} !== {vamt[i], vdir[i]}) begin failures++; $display("FAIL basic%0d_echo got=%0h/%0h exp=%0h/%0h", i, out_sh_amt, out_dir, vamt[i], vdir[i]); end
      step();
    end
    checks++; if (done_cnt !== 16'd4) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=4", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] data [6];
    int accepted;
    do_reset();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      data[i]   = 8'(i * 17 + 3);
      in_valid  = 1'b1; in_din = data[i]; in_sh_amt = 3'd0; in_dir = 1'b0;
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (accepted !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", accepted); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
    checks++; if (fifo_cnt !== 3'd4) begin failures++; $display("FAIL bp_fifo_cnt got=%0d exp=4", fifo_cnt); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%0h exp=1", out_valid); end
    step();
    checks++; if (out_dout !== data[0]) begin failures++; $display("FAIL bp_hold got=%0h exp=%0h", out_dout, data[0]); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (out_valid !== 1'b1 || out_dout !== data[j]) begin failures++; $display("FAIL bp_order%0d got=%0h/%0h exp=1/%0h", j, out_valid, out_dout, data[j]); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0h exp=0", out_valid); end
    checks++; if (done_cnt !== 16'd5) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=5", done_cnt); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q [16];
    for (int i = 0; i < 16; i++) begin
      exp_q[i] = (i < 8) ? 8'(8'hB3 << i) : 8'(8'hB3 >> (i - 8));
    end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      in_valid  = (c < 16);
      in_din    = 8'hB3;
      in_sh_amt = 3'(c % 8);
      in_dir    = (c >= 8);
      step();
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_dout !== exp_q[c-1]) begin failures++; $display("FAIL stream%0d got=%0h/%0h exp=1/%0h", c - 1, out_valid, out_dout, exp_q[c-1]); end
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (done_cnt !== 16'd16) begin failures++; $display("FAIL stream_done_cnt got=%0d exp=16", done_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_din = 8'h0F; in_sh_amt = 3'd1; in_dir = 1'b0;
    step();
    in_din = 8'hF0; in_sh_amt = 3'd4; in_dir = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (fifo_cnt !== 3'd1) begin failures++; $display("FAIL b2b_push_pop_cnt got=%0d exp=1", fifo_cnt); end
    checks++; if (out_valid !== 1'b1 || out_dout !== 8'h1E) begin failures++; $display("FAIL b2b_first got=%0h/%0h exp=1/1e", out_valid, out_dout); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_dout !== 8'h0F) begin failures++; $display("FAIL b2b_no_bubble got=%0h/%0h exp=1/0f", out_valid, out_dout); end
    checks++; if (fifo_cnt !== 3'd0) begin failures++; $display("FAIL b2b_cnt_after got=%0d exp=0", fifo_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_din = 8'(8'h21 + i); in_sh_amt = 3'd1; in_dir = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++; if (fifo_cnt !== 3'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_setup got=%0d/%0h exp=3/1", fifo_cnt, out_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_dout, out_sh_amt, out_dir, fifo_cnt, done_cnt} !== 32'h0) begin failures++; $display("FAIL mid_async_clear got=%0h/%0h/%0h/%0h/%0h/%0h exp=all0", out_valid, out_dout, out_sh_amt, out_dir, fifo_cnt, done_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0h exp=1", in_ready); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost%0d got=%0h exp=0", i, out_valid); end
    end
    in_valid = 1'b1; in_din = 8'h81; in_sh_amt = 3'd2; in_dir = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_dout !== 8'h20) begin failures++; $display("FAIL mid_new_cmd got=%0h/%0h exp=1/20", out_valid, out_dout); end
  endtask

  task automatic test_done_wrap();
    do_reset();
    out_ready = 1'b1;
    in_din = 8'h5A; in_sh_amt = 3'd0; in_dir = 1'b0;
    for (int e = 1; e <= 65539; e++) begin
      in_valid = (e <= 65537);
      step();
      if (e == 65537) begin
        checks++; if (done_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%0h exp=ffff", done_cnt); end
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (done_cnt !== 16'd1) begin failures++; $display("FAIL wrap_done_cnt got=%0h exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    test_done_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the data width; N SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the command FIFO depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a command is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the FIFO can accept a command.
REQ-007 The module SHALL have port in_din, input, N bits: data to shift.
REQ-008 The module SHALL have port in_sh_amt, input, $clog2(N) bits: shift amount.
REQ-009 The module SHALL have port in_dir, input, 1 bit: 0 = left shift, 1 = right shift.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the result register holds a result.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_dout, output, N bits: the shifted result.
REQ-013 The module SHALL have ports out_sh_amt and out_dir, outputs, $clog2(N) bits and 1 bit: the command fields echoed with the result.
REQ-014 The module SHALL have port fifo_cnt, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 The module SHALL have port done_cnt, output, 16 bits: count of results consumed, wrapping modulo 2^16.

Function
REQ-016 A command SHALL be accepted on a rising edge where in_valid && in_ready; in_ready SHALL equal (fifo_cnt != DEPTH) and SHALL NOT depend on out_ready.
REQ-017 The FIFO head SHALL feed the combinational shifter; the result SHALL be logical: zero-fill, no wrap-around of shifted-out bits, and sh_amt 0 SHALL pass data unchanged.
REQ-018 The head SHALL pop into the result register on an edge where the FIFO is not empty && (!out_valid || out_ready).
REQ-019 A result SHALL be consumed on an edge where out_valid && out_ready; done_cnt SHALL increment on that edge, wrapping 0xFFFF -> 0x0000.
REQ-020 out_valid SHALL clear on consume unless a pop occurs on the same edge, in which case the new result SHALL be loaded with no bubble.
REQ-021 Latency SHALL be exactly 2 edges: a command accepted at edge k into an empty FIFO with a free output SHALL be presented with out_valid=1 after edge k+1; there SHALL be no FIFO bypass.
REQ-022 A push and a pop on the same edge SHALL leave fifo_cnt unchanged.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH.
REQ-024 Results SHALL leave strictly in acceptance order; a command SHALL never be dropped or duplicated.
REQ-025 Sustained throughput SHALL be one result per cycle when in_valid=1 and out_ready=1.
REQ-026 out_dout, out_sh_amt and out_dir SHALL be held stable while out_valid && !out_ready.
REQ-027 Total buffering SHALL be DEPTH+1 commands (FIFO plus result register).

Reset
REQ-028 While rst=1, the block SHALL immediately set out_valid=0, out_dout=0, out_sh_amt=0, out_dir=0, fifo_cnt=0, done_cnt=0, clear the FIFO pointers, and drive in_ready=1.
REQ-029 Asserting reset mid-operation SHALL discard all in-flight commands and results; no result SHALL appear after reset is released until a new command is accepted.

Structure
REQ-030 The shared package barrel_pkg SHALL hold the default width constant, the direction encodings DIR_LEFT=0 and DIR_RIGHT=1, and the shift-amount width function.
REQ-031 The shifter SHALL be a single sub-module, barrel_shifter_logical (din, sh_amt, dir, dout), instantiated once on the FIFO head.
REQ-032 The FIFO and the result register SHALL be implemented in this module.

Verification
REQ-033 Basic shifts, with out_ready=1 and din=8'b10110011: dir=0, sh_amt=3 -> out_dout=8'b10011000 two edges after accept; dir=1, sh_amt=2 -> 8'b00101100; sh_amt=0 -> 8'b10110011; dir=0, sh_amt=7 -> 8'b10000000.
REQ-034 Backpressure: with out_ready=0, push 6 commands -> 5 accepted, then in_ready=0 and fifo_cnt=4 with out_valid=1; raise out_ready -> 5 results in order on consecutive cycles, done_cnt=5.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 16 commands of sh_amt 0..7 in both directions -> one result per cycle and done_cnt=16.
REQ-036 Simultaneous events: push and pop on the same edge with fifo_cnt=1 -> fifo_cnt stays 1; consume and load on the same edge -> out_valid stays 1 and the data changes.
REQ-037 Reset mid-operation: assert rst with fifo_cnt=3 and out_valid=1 -> all outputs 0 and in_ready=1 immediately; after release, no out_valid without a new push.
REQ-038 done_cnt wrap: consume 65537 results -> done_cnt=1.
